tlb_miss_queue: RTL and testbench
=================================

# tlb_miss_queue

Upstream feeder for the page walker. Collects data-TLB and code-TLB miss requests, holds up to DEPTH of them in a FIFO, and drops duplicate requests for a page already queued or being walked. Issues one request at a time on the walker's new_en/new_can handshake and keeps the walker slot owned until the walker signals a TLB write.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- except  in  1  pipeline flush; discards queued (not in-flight) entries
- d_en  in  1  data-side miss valid
- d_addr  in  48  data miss virtual address
- d_attr  in  4  data miss attributes (vm bit etc.), passed through
- d_inv  in  1  invalidate-walk request
- d_ack  out  1  data request accepted or deduplicated this cycle
- i_en  in  1  code-side miss valid
- i_addr  in  48  code miss virtual address
- i_attr  in  4  code miss attributes
- i_ack  out  1  code request accepted or deduplicated this cycle
- pg_en  out  1  request valid to walker (new_en)
- pg_can  in  1  walker can accept (new_can)
- pg_addr  out  48  head address
- pg_attr  out  4  head attributes
- pg_indir  out  1  tied 0
- pg_inv  out  1  head invalidate flag
- pg_permReq  out  1  0 = data, 1 = code
- pg_done  in  1  walker completion pulse (writeTlb_wen | writeTlb_wen_c | writeTlb_wenH_c)
- busy  out  1  queue non-empty or walk in flight
- dedup_hit  out  1  registered pulse: a request was dropped as a duplicate

## Operation
- Entry fields: addr[47:0], attr[3:0], inv, perm. FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- Arbitration: at most one request is accepted per cycle, and code has priority.
  - i_ack = i_en & ~full & ~except.
  - d_ack = d_en & ~i_en & ~full & ~except.
  - A requester that is not acked holds its request until it is.
- Duplicate check: an incoming request is a duplicate when it has inv=0 and its addr[43:14] and perm match any valid queue entry or the in-flight request (state WAIT, or the head being popped this cycle).
  - A duplicate is acked but not written; dedup_hit is asserted the next cycle.
  - Requests with inv=1 are never deduplicated.
- full = (count == DEPTH). It is evaluated from the registered count; there is no same-cycle pop bypass.
- FSM with two states, IDLE and WAIT.
  - IDLE: pg_en = ~empty. When pg_en & pg_can, the head is popped, its addr[43:14] and perm are latched as the in-flight request, and the state goes to WAIT.
  - WAIT: pg_en = 0. When pg_done, the state goes to IDLE.
  - pg_done while in IDLE is ignored.
- pg_addr, pg_attr, pg_inv and pg_permReq are driven combinationally from the head entry. They are don't-care when pg_en = 0.
- except: count is cleared and head is set equal to tail in the same cycle; no request is accepted that cycle. The in-flight walk continues and the FSM is unaffected.
- If except and a pop occur in the same cycle, the pop wins for the head entry: the walker has accepted it and it goes to WAIT. The rest of the queue is flushed.
- busy = (count != 0) | (state == WAIT).

## Timing
- Reset values: pg_en=0, d_ack=0, i_ack=0, busy=0, dedup_hit=0, count=0, head=tail=0, state IDLE.
- Enqueue to pg_en latency: 1 cycle. A request acked at edge N gives pg_en=1 in cycle N+1 when the queue was empty and state is IDLE.
- Pop occurs at the edge where pg_en & pg_can = 1. Since the state is then WAIT, pg_en is 0 in the following cycle.
- Walk-to-next-issue: pg_done at cycle M puts the FSM in IDLE at M+1, and pg_en=1 at M+1 if the queue is non-empty.
- Enqueue and pop in the same cycle leaves count unchanged.
- A full queue with a pop this cycle still refuses new requests this cycle.
- Pointers wrap from DEPTH-1 to 0 with no bubble.
- rst asserted mid-walk: the FSM returns to IDLE and the queue empties. The walker's own reset is relied upon, and a later pg_done is ignored.

## Test plan
- Single miss: i_en=1 with i_addr=0x0000_1234_4000 → i_ack=1. In the next cycle pg_en=1, pg_addr=0x0000_1234_4000, pg_permReq=1. Pulse pg_can, then pg_done 20 cycles later → busy falls to 0 one cycle after.
- Priority and fill: i_en and d_en held with distinct pages for 6 cycles while pg_can=0.
  - Expect i_ack for the first 4 accepted slots, then i_ack=d_ack=0 while full.
  - Pop order matches accept order.
- Duplicates:
  - d_addr=0x4000 twice with perm 0 → both acked, one entry, dedup_hit=1 once.
  - The same page with inv=1 → two entries.
  - The same page as the in-flight walk with d_addr=0x5FFF vs 0x4000 (identical bits [43:14]) → dropped.
- except with 3 queued and 1 in flight → count=0 the next cycle; pg_done then IDLE with pg_en=0.
- Same-cycle except and pop → the popped entry reaches WAIT and the other entries are flushed.
- Wrap-around: 10 enqueue/pop pairs with DEPTH=4 → addresses appear in order and count never exceeds 4. Additionally, rst during WAIT → all outputs return to their reset values.

Source files
------------

// File: rtl/tlb_miss_queue.sv
// tlb_miss_queue: collects data-side and code-side TLB misses into a small
// FIFO, drops requests whose page is already queued or being walked, and
// feeds the page walker one request at a time. The walker slot stays owned
// (state WAIT) from the accepted issue until the walker writes the TLB.
module tlb_miss_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except,
  input  logic        d_en,
  input  logic [47:0] d_addr,
  input  logic [3:0]  d_attr,
  input  logic        d_inv,
  output logic        d_ack,
  input  logic        i_en,
  input  logic [47:0] i_addr,
  input  logic [3:0]  i_attr,
  output logic        i_ack,
  output logic        pg_en,
  input  logic        pg_can,
  output logic [47:0] pg_addr,
  output logic [3:0]  pg_attr,
  output logic        pg_indir,
  output logic        pg_inv,
  output logic        pg_permReq,
  input  logic        pg_done,
  output logic        busy,
  output logic        dedup_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when storage slot idx lies inside the occupied window that starts
  // at head and spans cnt entries (modulo DEPTH).
  function automatic logic in_window(input logic [PW-1:0] idx,
                                     input logic [PW-1:0] head,
                                     input logic [CW-1:0] cnt);
    logic [PW-1:0] off;
    off = idx - head;
    return ({1'b0, off} < cnt);
  endfunction

  // Same translation page (bits 43:14) and same permission side.
  function automatic logic page_match(input logic [29:0] page_a,
                                      input logic        perm_a,
                                      input logic [29:0] page_b,
                                      input logic        perm_b);
    return (page_a == page_b) && (perm_a == perm_b);
  endfunction

  // Queue storage
  logic [47:0]   addr_q [DEPTH];
  logic [3:0]    attr_q [DEPTH];
  logic          inv_q  [DEPTH];
  logic          perm_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q, state_d;
  logic [29:0]   fl_page_q, fl_page_d;
  logic          fl_perm_q, fl_perm_d;
  logic          dedup_hit_q, dedup_hit_d;

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          any_ack_s;
  logic          dup_s;
  logic          hit_s;
  logic [PW-1:0] idx_s;

  logic [47:0]   req_addr_s;
  logic [3:0]    req_attr_s;
  logic          req_inv_s;
  logic          req_perm_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == DEPTH_C);

  // Arbitration: one acceptance per cycle, code side first; full is taken
  // from the registered count, so a pop this cycle does not free a slot yet.
  always_comb begin
    i_ack     = i_en & ~full_s & ~except;
    d_ack     = d_en & ~i_en & ~full_s & ~except;
    any_ack_s = i_ack | d_ack;
  end

  // Select the request that would be written this cycle.
  always_comb begin
    if (i_en) begin
      req_addr_s = i_addr;
      req_attr_s = i_attr;
      req_inv_s  = 1'b0;
      req_perm_s = 1'b1;
    end else begin
      req_addr_s = d_addr;
      req_attr_s = d_attr;
      req_inv_s  = d_inv;
      req_perm_s = 1'b0;
    end
  end

  // Duplicate search over queued entries and the in-flight walk. The head
  // being popped this cycle is still inside the occupied window, so it is
  // covered by the queue scan.
  always_comb begin
    hit_s = 1'b0;
    idx_s = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = PW'(k);
      hit_s = hit_s | (in_window(idx_s, head_q, count_q) &
                       page_match(addr_q[k][43:14], perm_q[k],
                                  req_addr_s[43:14], req_perm_s));
    end
    hit_s = hit_s | ((state_q == ST_WAIT) &
                     page_match(fl_page_q, fl_perm_q,
                                req_addr_s[43:14], req_perm_s));
    dup_s = ~req_inv_s & hit_s;
  end

  assign push_s = any_ack_s & ~dup_s;

  // FSM output decode: issue only from IDLE with something queued.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        pg_en = ~empty_s;
        busy  = ~empty_s;
      end
      ST_WAIT: begin
        pg_en = 1'b0;
        busy  = 1'b1;
      end
      default: begin
        pg_en = 1'b0;
        busy  = 1'b1;
      end
    endcase
  end

  assign pop_s = pg_en & pg_can;

  // FSM next state: accepted issue -> WAIT, walker TLB write -> IDLE.
  always_comb begin
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (pg_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pointer / count / in-flight next state. A flush empties the queue but
  // a simultaneous pop still hands the head to the walker.
  always_comb begin
    tail_d      = tail_q;
    head_d      = head_q;
    count_d     = count_q;
    fl_page_d   = fl_page_q;
    fl_perm_d   = fl_perm_q;
    dedup_hit_d = any_ack_s & dup_s;

    if (pop_s) begin
      fl_page_d = addr_q[head_q][43:14];
      fl_perm_d = perm_q[head_q];
    end else begin
      fl_page_d = fl_page_q;
      fl_perm_d = fl_perm_q;
    end

    if (except) begin
      head_d  = tail_q;
      count_d = CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count, in-flight tag and dedup pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= {PW{1'b0}};
      tail_q      <= {PW{1'b0}};
      count_q     <= CNT_ZERO;
      fl_page_q   <= 30'd0;
      fl_perm_q   <= 1'b0;
      dedup_hit_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fl_page_q   <= fl_page_d;
      fl_perm_q   <= fl_perm_d;
      dedup_hit_q <= dedup_hit_d;
    end
  end

  // Entry storage: write the accepted, non-duplicate request at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        addr_q[k] <= 48'd0;
        attr_q[k] <= 4'd0;
        inv_q[k]  <= 1'b0;
        perm_q[k] <= 1'b0;
      end
    end else if (push_s) begin
      addr_q[tail_q] <= req_addr_s;
      attr_q[tail_q] <= req_attr_s;
      inv_q[tail_q]  <= req_inv_s;
      perm_q[tail_q] <= req_perm_s;
    end
  end

  // Head entry drives the walker request fields directly.
  assign pg_addr    = addr_q[head_q];
  assign pg_attr    = attr_q[head_q];
  assign pg_inv     = inv_q[head_q];
  assign pg_permReq = perm_q[head_q];
  assign pg_indir   = 1'b0;
  assign dedup_hit  = dedup_hit_q;

endmodule

// File: tb/tb_tlb_miss_queue.sv
// Directed bench for tlb_miss_queue: inputs change 1 ns after the rising
// edge, outputs are sampled 2 ns later.
module tb_tlb_miss_queue;

  logic        clk;
  logic        rst;
  logic        except;
  logic        d_en;
  logic [47:0] d_addr;
  logic [3:0]  d_attr;
  logic        d_inv;
  logic        d_ack;
  logic        i_en;
  logic [47:0] i_addr;
  logic [3:0]  i_attr;
  logic        i_ack;
  logic        pg_en;
  logic        pg_can;
  logic [47:0] pg_addr;
  logic [3:0]  pg_attr;
  logic        pg_indir;
  logic        pg_inv;
  logic        pg_permReq;
  logic        pg_done;
  logic        busy;
  logic        dedup_hit;

  int checks = 0;
  int errors = 0;

  tlb_miss_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .except(except),
    .d_en(d_en), .d_addr(d_addr), .d_attr(d_attr), .d_inv(d_inv), .d_ack(d_ack),
    .i_en(i_en), .i_addr(i_addr), .i_attr(i_attr), .i_ack(i_ack),
    .pg_en(pg_en), .pg_can(pg_can), .pg_addr(pg_addr), .pg_attr(pg_attr),
    .pg_indir(pg_indir), .pg_inv(pg_inv), .pg_permReq(pg_permReq),
    .pg_done(pg_done), .busy(busy), .dedup_hit(dedup_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk48(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] page(input int p);
    logic [47:0] v;
    v = 48'(p);
    return v << 14;
  endfunction

  initial begin
    rst = 1'b1; except = 1'b0;
    d_en = 1'b0; d_addr = 48'd0; d_attr = 4'd0; d_inv = 1'b0;
    i_en = 1'b0; i_addr = 48'd0; i_attr = 4'd0;
    pg_can = 1'b0; pg_done = 1'b0;

    // Reset state
    tick(); tick(); look();
    chk1("rst_pg_en", pg_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_dedup", dedup_hit, 1'b0);
    chk1("rst_i_ack", i_ack, 1'b0);
    chk1("rst_d_ack", d_ack, 1'b0);
    chk1("pg_indir", pg_indir, 1'b0);
    rst = 1'b0;

    // Single code miss
    tick();
    i_en = 1'b1; i_addr = 48'h0000_1234_4000; look();
    chk1("single_i_ack", i_ack, 1'b1);
    chk1("single_pg_en_before", pg_en, 1'b0);
    tick();
    i_en = 1'b0; look();
    chk1("single_pg_en", pg_en, 1'b1);
    chk48("single_pg_addr", pg_addr, 48'h0000_1234_4000);
    chk1("single_perm", pg_permReq, 1'b1);
    chk1("single_busy", busy, 1'b1);
    pg_can = 1'b1;
    tick();
    pg_can = 1'b0; look();
    chk1("single_wait_pg_en", pg_en, 1'b0);
    chk1("single_wait_busy", busy, 1'b1);
    repeat (19) tick();
    pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("single_done_busy", busy, 1'b0);

    // Priority and fill: code wins, 4 slots, then refused while full
    i_en = 1'b1; d_en = 1'b1; d_addr = page(32'h40);
    for (int k = 0; k < 6; k++) begin
      i_addr = (k < 4) ? page(16 + k) : page(20);
      look();
      chk1("fill_i_ack", i_ack, (k < 4) ? 1'b1 : 1'b0);
      chk1("fill_d_ack", d_ack, 1'b0);
      tick();
    end
    i_en = 1'b0; look();
    chk1("full_d_ack", d_ack, 1'b0);
    pg_can = 1'b1; look();
    chk1("full_pop_refuse", d_ack, 1'b0);
    d_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("order_pg_en", pg_en, 1'b1);
      chk48("order_addr", pg_addr, page(16 + k));
      chk1("order_perm", pg_permReq, 1'b1);
      pg_can = 1'b1;
      tick();
      pg_can = 1'b0; look();
      chk1("order_wait", pg_en, 1'b0);
      pg_done = 1'b1;
      tick();
      pg_done = 1'b0; look();
    end
    chk1("fill_drained", busy, 1'b0);

    // Duplicates against queue and in-flight walk
    d_en = 1'b1; d_addr = 48'h4000; d_inv = 1'b0; d_attr = 4'h3; look();
    chk1("dup_first_ack", d_ack, 1'b1);
    tick(); look();
    chk1("dup_no_hit_yet", dedup_hit, 1'b0);
    chk1("dup_second_ack", d_ack, 1'b1);
    tick();
    d_en = 1'b0; look();
    chk1("dup_hit", dedup_hit, 1'b1);
    tick(); look();
    chk1("dup_hit_pulse", dedup_hit, 1'b0);
    chk1("dup_pg_en", pg_en, 1'b1);
    chk48("dup_pg_addr", pg_addr, 48'h4000);
    chk1("dup_perm", pg_permReq, 1'b0);
    chk48("dup_attr", {44'd0, pg_attr}, 48'h3);
    pg_can = 1'b1;
    tick();
    pg_can = 1'b0; d_en = 1'b1; d_addr = 48'h5FFF; look();
    chk1("dup_fl_ack", d_ack, 1'b1);
    tick();
    d_en = 1'b0; look();
    chk1("dup_fl_hit", dedup_hit, 1'b1);
    chk1("dup_fl_pg_en", pg_en, 1'b0);
    pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("dup_one_entry", busy, 1'b0);

    // inv=1 is never deduplicated
    d_en = 1'b1; d_addr = 48'h4000; d_inv = 1'b1; look();
    chk1("inv_ack1", d_ack, 1'b1);
    tick(); look();
    chk1("inv_ack2", d_ack, 1'b1);
    tick();
    d_en = 1'b0; d_inv = 1'b0; look();
    chk1("inv_no_hit", dedup_hit, 1'b0);
    chk1("inv_flag1", pg_inv, 1'b1);
    pg_can = 1'b1;
    tick();
    pg_can = 1'b0; pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("inv_second_entry", pg_en, 1'b1);
    chk1("inv_flag2", pg_inv, 1'b1);
    pg_can = 1'b1;
    tick();
    pg_can = 1'b0; pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("inv_drained", busy, 1'b0);

    // except with 3 queued and 1 in flight; enqueue+pop keeps count
    i_en = 1'b1; i_addr = page(32'h20);
    tick();
    i_addr = page(32'h21); pg_can = 1'b1; look();
    chk1("exc_push_pop_ack", i_ack, 1'b1);
    chk48("exc_head", pg_addr, page(32'h20));
    tick();
    pg_can = 1'b0; i_addr = page(32'h22);
    tick();
    i_addr = page(32'h23);
    tick();
    i_addr = page(32'h24); look();
    chk1("exc_count3_not_full", i_ack, 1'b1);
    i_en = 1'b0; look();
    chk1("exc_wait_pg_en", pg_en, 1'b0);
    except = 1'b1; i_en = 1'b1; i_addr = page(32'h25); look();
    chk1("exc_no_accept", i_ack, 1'b0);
    tick();
    except = 1'b0; i_en = 1'b0; look();
    chk1("exc_still_busy", busy, 1'b1);
    pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("exc_idle_pg_en", pg_en, 1'b0);
    chk1("exc_idle_busy", busy, 1'b0);

    // Same-cycle except and pop
    i_en = 1'b1; i_addr = page(32'h30);
    tick();
    i_addr = page(32'h31);
    tick();
    i_addr = page(32'h32);
    tick();
    i_en = 1'b0; except = 1'b1; pg_can = 1'b1; look();
    chk1("xp_pg_en", pg_en, 1'b1);
    chk48("xp_head", pg_addr, page(32'h30));
    tick();
    except = 1'b0; pg_can = 1'b0; look();
    chk1("xp_wait", pg_en, 1'b0);
    chk1("xp_busy", busy, 1'b1);
    pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("xp_flushed", busy, 1'b0);
    i_en = 1'b1; i_addr = page(32'h3F); look();
    chk1("xp_new_ack", i_ack, 1'b1);
    tick();
    i_en = 1'b0; look();
    chk48("xp_new_head", pg_addr, page(32'h3F));
    pg_can = 1'b1;
    tick();
    pg_can = 1'b0; pg_done = 1'b1;
    tick();
    pg_done = 1'b0;

    // Wrap-around: 10 enqueue/pop pairs
    for (int k = 0; k < 10; k++) begin
      d_en = 1'b1; d_addr = page(32'h100 + k) | 48'h123; d_attr = 4'(k); look();
      chk1("wrap_ack", d_ack, 1'b1);
      tick();
      d_en = 1'b0; look();
      chk1("wrap_pg_en", pg_en, 1'b1);
      chk48("wrap_addr", pg_addr, page(32'h100 + k) | 48'h123);
      chk48("wrap_attr", {44'd0, pg_attr}, 48'(k % 16));
      pg_can = 1'b1;
      tick();
      pg_can = 1'b0; pg_done = 1'b1;
      tick();
      pg_done = 1'b0;
    end
    look();
    chk1("wrap_drained", busy, 1'b0);

    // rst during WAIT
    i_en = 1'b1; i_addr = page(32'h200);
    tick();
    i_addr = page(32'h201);
    tick();
    i_en = 1'b0; pg_can = 1'b1;
    tick();
    pg_can = 1'b0; i_en = 1'b1; i_addr = page(32'h201); look();
    chk1("rstw_dup_ack", i_ack, 1'b1);
    tick();
    i_en = 1'b0; look();
    chk1("rstw_dup_hit", dedup_hit, 1'b1);
    chk1("rstw_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0; look();
    chk1("rstw_pg_en", pg_en, 1'b0);
    chk1("rstw_busy0", busy, 1'b0);
    chk1("rstw_dedup0", dedup_hit, 1'b0);
    chk1("rstw_i_ack", i_ack, 1'b0);
    chk1("rstw_d_ack", d_ack, 1'b0);
    pg_done = 1'b1;
    tick();
    pg_done = 1'b0; look();
    chk1("rstw_late_done_pg_en", pg_en, 1'b0);
    chk1("rstw_late_done_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
